wb_spi_sram: RTL and testbench
==============================

# wb_spi_sram

Wishbone classic slave that serves each single-beat read or write by running one SPI mode-0 frame against an external serial SRAM (23LC1024-class: 0x03 READ, 0x02 WRITE, 24-bit address). It sits on a slave port of the Wishbone interconnect, typically slave 1, the upper address region. It is the responder end of the bus the masters drive: it owns `ack`/`err`/`rty`/`dat` and turns bus cycles into pin activity.

## Interface
- `ADDR_WIDTH`, default 24: Wishbone address width, ≤24. The address is zero-extended to 24 bits on the wire.
- `DATA_WIDTH`, default 8: data width. Must be 8.
- `SEL_WIDTH`, default `DATA_WIDTH/8`: select width.
- `CLK_DIV`, default 1: SCK half-period in `clk_i` cycles, ≥1.
- `MEM_BYTES`, default 131072: device size, used only with the error feature.

Ports:
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `wb_cyc_i` in 1: cycle.
- `wb_stb_i` in 1: strobe.
- `wb_adr_i` in `ADDR_WIDTH`: byte address.
- `wb_we_i` in 1: write enable.
- `wb_sel_i` in `SEL_WIDTH`: byte select.
- `wb_dat_i` in `DATA_WIDTH`: write data.
- `wb_ack_o` out 1: acknowledge.
- `wb_err_o` out 1: error.
- `wb_rty_o` out 1: retry, tied 0.
- `wb_dat_o` out `DATA_WIDTH`: read data, registered.
- `spi_sck_o` out 1: serial clock, idle low.
- `spi_cs_n_o` out 1: chip select, active low.
- `spi_mosi_o` out 1: serial data to the device.
- `spi_miso_i` in 1: serial data from the device.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE → SHIFT when `wb_cyc_i & wb_stb_i`.
  - Latch `adr`, `we`, `dat`.
  - Load the 40-bit frame `{cmd[7:0], addr24, wdata}`. `cmd` is 0x02 when `we` is set, else 0x03.
  - Read frames shift out `wdata` = 0x00.
- Write with `wb_sel_i == 0`: no frame runs. `wb_ack_o` is asserted the cycle after accept.
- SHIFT:
  - 40 bits, MSB first.
  - MOSI changes on SCK falling edges (and at CS fall).
  - MISO is sampled into a shift register on SCK rising edges.
  - For reads, the last 8 samples are the data byte.
- SHIFT → DONE after the 40th falling edge. In DONE:
  - `spi_cs_n_o` goes high.
  - `wb_ack_o` = 1 for exactly one cycle.
  - On a read, `wb_dat_o` is updated in the same cycle.
- DONE → IDLE unconditionally. No request is accepted in DONE.
- `wb_cyc_i` dropped mid-frame: the frame completes on the pins, so a write still lands. `wb_ack_o` is suppressed if `wb_cyc_i` is low in DONE.
- Reset values, on the cycle after `rst_i` is sampled high, including mid-frame:
  - `spi_cs_n_o` = 1
  - `spi_sck_o` = 0
  - `spi_mosi_o` = 0
  - `wb_ack_o` = 0, `wb_err_o` = 0
  - `wb_dat_o` = 0
  - state IDLE
- Master inputs are ignored while `rst_i` is high.
- `wb_dat_o` holds the last read value until the next read completes.

## Timing
Cycle 0 is the IDLE cycle in which the request is sampled.
- Cycle 1:
  - `spi_cs_n_o` falls.
  - `spi_mosi_o` = frame bit 39.
- Bit k (k = 0..39):
  - SCK rises at cycle 1 + (2k+1)·`CLK_DIV`.
  - SCK falls at cycle 1 + (2k+2)·`CLK_DIV`.
- DONE (CS high, ack) is cycle 1 + 80·`CLK_DIV`. With `CLK_DIV`=1 this is cycle 81.
- Next request can be sampled at cycle 2 + 80·`CLK_DIV` at the earliest. CS therefore stays high for ≥2 cycles between frames.
- The ack is combinationally independent of `wb_stb_i`, so there is no same-cycle ack.

## Configuration
- `WB_SPI_SRAM_ERR_EN` defined:
  - An access with the 24-bit address ≥ `MEM_BYTES` starts no frame.
  - `wb_err_o` = 1 for one cycle at cycle 1.
  - `wb_ack_o` stays 0 and `wb_dat_o` is unchanged.
- `WB_SPI_SRAM_ERR_EN` undefined:
  - `wb_err_o` is tied 0.
  - All addresses run a frame and the device wraps internally.

## Test plan
- Write 0xA5 to 0x012345, `CLK_DIV`=1:
  - MOSI stream is 0x02, 0x01, 0x23, 0x45, 0xA5 over 40 SCK edges.
  - CS low cycles 1–80.
  - Ack at cycle 81 only.
- Read 0x000010 with a MISO model returning 0x3C, `CLK_DIV`=2:
  - MOSI stream is 0x03, 0x00, 0x00, 0x10, 0x00.
  - Ack at cycle 161 with `wb_dat_o` = 0x3C.
  - `wb_dat_o` still 0x3C 10 cycles later.
- Back-to-back reads with `wb_stb_i` held high through ack:
  - Exactly one ack per frame.
  - CS high ≥2 cycles between frames.
- `rst_i` pulsed at cycle 30 of a write:
  - Cycle 31: `spi_cs_n_o`=1, `spi_sck_o`=0.
  - No ack.
  - A new request at cycle 35 starts a clean frame.
- `wb_cyc_i` dropped at cycle 40 of a write: the frame finishes at cycle 80 and no ack is issued.
- `WB_SPI_SRAM_ERR_EN` defined, read 0x020000 with `MEM_BYTES`=131072:
  - `wb_err_o`=1 at cycle 1.
  - `spi_cs_n_o` stays 1.
  - No ack.

Source files
------------

// File: rtl/wb_spi_sram.sv
// Wishbone classic slave that runs one SPI mode-0 frame per single-beat access against a
// 23LC1024-class serial SRAM. Define WB_SPI_SRAM_ERR_EN to reject addresses >= MEM_BYTES.
module wb_spi_sram #(
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SEL_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned CLK_DIV    = 1,
  parameter int unsigned MEM_BYTES  = 131072
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic                  wb_we_i,
  input  logic [SEL_WIDTH-1:0]  wb_sel_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_rty_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  spi_sck_o,
  output logic                  spi_cs_n_o,
  output logic                  spi_mosi_o,
  input  logic                  spi_miso_i
);

  localparam int unsigned FRAME_BITS = 40;
  localparam int unsigned BIT_CNT_W  = 6;
  localparam int unsigned DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [FRAME_BITS-1:0]   frame_q, frame_d;
  logic [7:0]              rx_q, rx_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic                    we_q, we_d;
  logic                    lost_q, lost_d;
  logic                    sck_q, sck_d;
  logic                    cs_n_q, cs_n_d;
  logic                    mosi_q, mosi_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;

  logic [23:0]             req_addr;
  logic [FRAME_BITS-1:0]   req_frame;
  logic                    addr_bad;

  // Command, zero-extended address and write byte (0x00 filler on reads)
  assign req_addr  = 24'(wb_adr_i);
  assign req_frame = {(wb_we_i ? 8'h02 : 8'h03), req_addr, (wb_we_i ? 8'(wb_dat_i) : 8'h00)};

`ifdef WB_SPI_SRAM_ERR_EN
  assign addr_bad = 32'(req_addr) >= 32'(MEM_BYTES);
`else
  logic unused_mem_bytes;
  assign addr_bad         = 1'b0;
  assign unused_mem_bytes = ^32'(MEM_BYTES);
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    rx_d      = rx_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    we_d      = we_q;
    lost_d    = lost_q;
    sck_d     = sck_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    dat_d     = dat_q;

    case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          we_d      = wb_we_i;
          lost_d    = 1'b0;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          frame_d   = req_frame;
          if (addr_bad) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else if (wb_we_i && (wb_sel_i == '0)) begin
            state_d = DONE;
            ack_d   = 1'b1;
          end else begin
            state_d = SHIFT;
            cs_n_d  = 1'b0;
            mosi_d  = req_frame[FRAME_BITS-1];
          end
        end
      end

      SHIFT: begin
        // An abandoned cycle still finishes on the pins but is never acknowledged
        if (!wb_cyc_i) lost_d = 1'b1;
        if (div_cnt_q == DIV_W'(CLK_DIV - 1)) begin
          div_cnt_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
            rx_d  = {rx_q[6:0], spi_miso_i};
          end else begin
            sck_d = 1'b0;
            if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1)) begin
              state_d = DONE;
              cs_n_d  = 1'b1;
              mosi_d  = 1'b0;
              ack_d   = wb_cyc_i && !lost_q;
              if (!we_q) dat_d = DATA_WIDTH'(rx_q);
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
              frame_d   = {frame_q[FRAME_BITS-2:0], 1'b0};
              mosi_d    = frame_q[FRAME_BITS-2];
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      rx_q      <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      we_q      <= 1'b0;
      lost_q    <= 1'b0;
      sck_q     <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_q     <= '0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      rx_q      <= rx_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      we_q      <= we_d;
      lost_q    <= lost_d;
      sck_q     <= sck_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      dat_q     <= dat_d;
    end
  end

  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign wb_rty_o   = 1'b0;
  assign wb_dat_o   = dat_q;
  assign spi_sck_o  = sck_q;
  assign spi_cs_n_o = cs_n_q;
  assign spi_mosi_o = mosi_q;

endmodule

// File: tb/tb_wb_spi_sram.sv
// Directed bench for wb_spi_sram: one instance at CLK_DIV=1, one at CLK_DIV=2, with a
// serial-SRAM MISO model that returns miso_byte in the data phase of a frame.
module tb_wb_spi_sram;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we, sel, use2;
  logic [23:0] adr;
  logic [7:0]  wdat;
  logic [7:0]  miso_byte;
  logic        miso;

  logic       ack1, err1, rty1, sck1, cs1, mosi1;
  logic       ack2, err2, rty2, sck2, cs2, mosi2;
  logic [7:0] dat1, dat2;

  logic       m_ack, m_err, m_sck, m_cs_n, m_mosi;
  logic [7:0] m_dat;

  always #5 clk = ~clk;

  wb_spi_sram #(.CLK_DIV(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc & ~use2), .wb_stb_i(stb), .wb_adr_i(adr),
    .wb_we_i(we), .wb_sel_i(sel), .wb_dat_i(wdat), .wb_ack_o(ack1), .wb_err_o(err1),
    .wb_rty_o(rty1), .wb_dat_o(dat1), .spi_sck_o(sck1), .spi_cs_n_o(cs1),
    .spi_mosi_o(mosi1), .spi_miso_i(miso)
  );

  wb_spi_sram #(.CLK_DIV(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc & use2), .wb_stb_i(stb), .wb_adr_i(adr),
    .wb_we_i(we), .wb_sel_i(sel), .wb_dat_i(wdat), .wb_ack_o(ack2), .wb_err_o(err2),
    .wb_rty_o(rty2), .wb_dat_o(dat2), .spi_sck_o(sck2), .spi_cs_n_o(cs2),
    .spi_mosi_o(mosi2), .spi_miso_i(miso)
  );

  assign m_ack  = use2 ? ack2  : ack1;
  assign m_err  = use2 ? err2  : err1;
  assign m_sck  = use2 ? sck2  : sck1;
  assign m_cs_n = use2 ? cs2   : cs1;
  assign m_mosi = use2 ? mosi2 : mosi1;
  assign m_dat  = use2 ? dat2  : dat1;

  // Device model: counts SCK rises since CS fell, drives data bits 32..39 MSB first
  logic m_sck_q  = 1'b0;
  int   rise_cnt = 0;
  always @(posedge clk) begin
    if (m_cs_n) rise_cnt <= 0;
    else if (m_sck && !m_sck_q) rise_cnt <= rise_cnt + 1;
    m_sck_q <= m_sck;
  end
  always_comb begin
    miso = 1'b1;
    if (rise_cnt >= 32 && rise_cnt < 40) miso = miso_byte[3'(39 - rise_cnt)];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  int          cs_first, cs_last, cs_low_n, ack_n, ack_t, err_n, err_t, rises, gap_min;
  logic [63:0] mosi_sr;
  logic [7:0]  dat_at_ack;
  logic        snap_cs, snap_sck, snap_mosi;

  task automatic req(input logic u2, input logic [23:0] a, input logic w,
                     input logic [7:0] d, input logic s);
    @(negedge clk);
    use2 = u2; adr = a; we = w; wdat = d; sel = s; cyc = 1'b1; stb = 1'b1;
  endtask

  // Samples cycle t (t=1 is the cycle after the request is sampled) #1 after each edge
  task automatic observe(input int n, input int hold_acks, input int drop_at, input int rst_at);
    logic sck_prev, seen_low;
    int   high_run;
    sck_prev = 1'b0; seen_low = 1'b0; high_run = 0;
    cs_first = -1; cs_last = -1; cs_low_n = 0; ack_n = 0; ack_t = -1;
    err_n = 0; err_t = -1; rises = 0; gap_min = 1000; mosi_sr = '0; dat_at_ack = '0;
    for (int t = 1; t <= n; t++) begin
      @(posedge clk); #1;
      if (!m_cs_n) begin
        if (seen_low && high_run > 0 && high_run < gap_min) gap_min = high_run;
        if (cs_first < 0) cs_first = t;
        cs_last = t; cs_low_n++; seen_low = 1'b1; high_run = 0;
      end else begin
        high_run++;
      end
      if (m_sck && !sck_prev) begin
        rises++;
        mosi_sr = {mosi_sr[62:0], m_mosi};
      end
      sck_prev = m_sck;
      if (m_ack) begin ack_n++; ack_t = t; dat_at_ack = m_dat; end
      if (m_err) begin err_n++; err_t = t; end
      if (t == rst_at + 1) begin snap_cs = m_cs_n; snap_sck = m_sck; snap_mosi = m_mosi; end
      if (t == rst_at) rst = 1'b1;
      else if (t == rst_at + 1) rst = 1'b0;
      if (t == drop_at || m_err || (m_ack && ack_n >= hold_acks)) begin
        cyc = 1'b0; stb = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 1'b0; use2 = 1'b0;
    adr = '0; wdat = '0; miso_byte = '0;
    snap_cs = 1'b0; snap_sck = 1'b1; snap_mosi = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs1",   64'(cs1),   64'd1);
    check("rst_sck1",  64'(sck1),  64'd0);
    check("rst_mosi1", 64'(mosi1), 64'd0);
    check("rst_ack1",  64'(ack1),  64'd0);
    check("rst_err1",  64'(err1),  64'd0);
    check("rst_rty1",  64'(rty1),  64'd0);
    check("rst_dat1",  64'(dat1),  64'd0);
    check("rst_cs2",   64'(cs2),   64'd1);
    check("rst_dat2",  64'(dat2),  64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Write 0xA5 to 0x012345, CLK_DIV=1
    req(1'b0, 24'h012345, 1'b1, 8'hA5, 1'b1);
    observe(90, 1, -1, -1);
    check("wr_mosi",    64'(mosi_sr[39:0]), 64'h02012345A5);
    check("wr_rises",   64'(rises),    64'd40);
    check("wr_cs_first",64'(cs_first), 64'd1);
    check("wr_cs_last", 64'(cs_last),  64'd80);
    check("wr_cs_low",  64'(cs_low_n), 64'd80);
    check("wr_ack_n",   64'(ack_n),    64'd1);
    check("wr_ack_t",   64'(ack_t),    64'd81);
    check("wr_err_n",   64'(err_n),    64'd0);
    repeat (3) @(posedge clk);

    // Read 0x000010 returning 0x3C, CLK_DIV=2 (write data must not leak into the frame)
    miso_byte = 8'h3C;
    req(1'b1, 24'h000010, 1'b0, 8'hFF, 1'b1);
    observe(161, 1, -1, -1);
    check("rd_mosi",    64'(mosi_sr[39:0]), 64'h0300001000);
    check("rd_cs_first",64'(cs_first), 64'd1);
    check("rd_cs_last", 64'(cs_last),  64'd160);
    check("rd_ack_n",   64'(ack_n),    64'd1);
    check("rd_ack_t",   64'(ack_t),    64'd161);
    check("rd_dat",     64'(dat_at_ack), 64'h3C);
    repeat (10) @(posedge clk);
    #1;
    check("rd_dat_hold", 64'(dat2), 64'h3C);

    // Back-to-back reads with strobe held through the first ack
    miso_byte = 8'h5A;
    req(1'b0, 24'h000200, 1'b0, 8'h00, 1'b1);
    observe(170, 2, -1, -1);
    check("b2b_ack_n",  64'(ack_n),    64'd2);
    check("b2b_ack_t",  64'(ack_t),    64'd163);
    check("b2b_gap",    64'(gap_min),  64'd2);
    check("b2b_cs_low", 64'(cs_low_n), 64'd160);
    check("b2b_dat",    64'(dat_at_ack), 64'h5A);
    repeat (3) @(posedge clk);

    // Write with no byte selected: ack next cycle, no frame
    req(1'b0, 24'h000300, 1'b1, 8'h77, 1'b0);
    observe(10, 1, -1, -1);
    check("sel0_ack_n",  64'(ack_n),    64'd1);
    check("sel0_ack_t",  64'(ack_t),    64'd1);
    check("sel0_cs_low", 64'(cs_low_n), 64'd0);
    repeat (3) @(posedge clk);

    // Cycle dropped at cycle 40 of a write: frame completes, no ack
    req(1'b0, 24'h000100, 1'b1, 8'hC3, 1'b1);
    observe(90, 1, 40, -1);
    check("drop_mosi",    64'(mosi_sr[39:0]), 64'h02000100C3);
    check("drop_rises",   64'(rises),   64'd40);
    check("drop_cs_last", 64'(cs_last), 64'd80);
    check("drop_ack_n",   64'(ack_n),   64'd0);
    repeat (3) @(posedge clk);

    // Reset pulsed at cycle 30 of a write, new read at cycle 35
    req(1'b0, 24'h000777, 1'b1, 8'h11, 1'b1);
    observe(35, 1, 30, 30);
    check("rst_mid_cs",   64'(snap_cs),   64'd1);
    check("rst_mid_sck",  64'(snap_sck),  64'd0);
    check("rst_mid_mosi", 64'(snap_mosi), 64'd0);
    check("rst_mid_ack",  64'(ack_n),     64'd0);
    miso_byte = 8'h96;
    req(1'b0, 24'h000020, 1'b0, 8'h00, 1'b1);
    observe(90, 1, -1, -1);
    check("post_rst_mosi",    64'(mosi_sr[39:0]), 64'h0300002000);
    check("post_rst_cs_first",64'(cs_first), 64'd1);
    check("post_rst_cs_last", 64'(cs_last),  64'd80);
    check("post_rst_ack_t",   64'(ack_t),    64'd81);
    check("post_rst_dat",     64'(dat_at_ack), 64'h96);
    repeat (3) @(posedge clk);

    // Read at 0x020000: out of range when the error feature is built in
`ifdef WB_SPI_SRAM_ERR_EN
    req(1'b0, 24'h020000, 1'b0, 8'h00, 1'b1);
    observe(20, 1, -1, -1);
    check("oob_err_n",  64'(err_n),    64'd1);
    check("oob_err_t",  64'(err_t),    64'd1);
    check("oob_cs_low", 64'(cs_low_n), 64'd0);
    check("oob_ack_n",  64'(ack_n),    64'd0);
    check("oob_dat",    64'(m_dat),    64'h96);
`else
    miso_byte = 8'h21;
    req(1'b0, 24'h020000, 1'b0, 8'h00, 1'b1);
    observe(90, 1, -1, -1);
    check("oob_err_n", 64'(err_n),  64'd0);
    check("oob_mosi",  64'(mosi_sr[39:0]), 64'h0302000000);
    check("oob_ack_t", 64'(ack_t),  64'd81);
    check("oob_dat",   64'(dat_at_ack), 64'h21);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
